seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Drives a multiplexed NDIG-digit seven-segment display from a binary value (score, counter) through one shared registered seg_decoder instance. It converts the binary input to BCD sequentially (shift-add-3), stores the digits, and time-shares the decoder across digits with a refresh scan. It sits between game/score logic and seg_decoder plus the board anode pins.

Parameters:
NDIG, 4, number of digits scanned; digit 0 = ones, driven by an[0]
BIN_W, 14, width of binary input
SCAN_DIV, 100000, clk cycles per digit slot; must be >= 4
MAXVAL, 9999, saturation value; equals 10^NDIG-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
bin  in  BIN_W  binary value to display; sampled only on accepted load
load  in  1  one-cycle strobe requesting conversion of bin
busy  out  1  high while a conversion is in progress
num  out  4  BCD digit to seg_decoder num input, registered
an  out  NDIG  anode enables, active-low, one-hot-low or all ones
ovf  out  1  high when the last committed value saturated

Behaviour:
- Single clock domain. Reset is synchronous, active-low: on a clk edge with rst_n=0, all state is reset regardless of other inputs.
- Reset values: state=IDLE, busy=0, ovf=0, num=0, an=all ones, digit regs=0, scan idx=0, div cnt=0, pending=0, pend_val=0.
- Conversion FSM, states IDLE, SHIFT, COMMIT:
  - IDLE + load: capture sat(bin) into shift reg; next state SHIFT; shift cnt=0; BCD work regs=0. sat(x)=MAXVAL if x>MAXVAL, else x. Record ovf_nxt=(x>MAXVAL).
  - SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left 1. Exactly BIN_W cycles, then go to COMMIT.
  - COMMIT: 1 cycle. Copy the BCD nibbles to the display digit regs atomically and update ovf. If pending=1, load pend_val, clear pending, and go to SHIFT. Otherwise go to IDLE.
  - busy=1 in every cycle where state!=IDLE. A load at cycle t gives busy=1 for cycles t+1..t+BIN_W+1; digit regs show the new value from cycle t+BIN_W+2.
  - load while busy: set pending=1 and overwrite pend_val with sat(bin). Only the latest pending value is kept; it never aborts the running conversion.
  - Simultaneous load and COMMIT-with-pending: the new bin wins. It is captured directly as the next conversion, and pending stays 0.
- Scan:
  - div cnt counts 0..SCAN_DIV-1 and wraps. On wrap, idx increments mod NDIG (order 0,1,..,NDIG-1,0).
  - num is registered as num <= digit[idx], so it changes 1 cycle after idx. seg_decoder adds 1 more cycle.
  - an is all ones when div cnt is 0 or 1 (ghost blanking covers the 2-cycle pipeline). Otherwise an has bit idx=0 and the rest 1, unless that digit is blanked.
- Leading-zero blanking:
  - Digit i>0 is blanked (its an bit stays 1) when digit regs i..NDIG-1 are all zero.
  - Digit 0 is never blanked.
  - Blanking uses the committed digits only. num is never driven above 9, because the decoder holds its output on illegal codes.
- Digit regs change only in COMMIT, so a display update mid-slot takes effect on the next num register cycle, with no torn values.
- Reset mid-conversion: the conversion is discarded, pending is cleared, and the display returns to 0.

Test Plan:
- Reset and blanking (SCAN_DIV=4 in sim): hold rst_n=0 3 cycles, release. Expect an=1111 in cycles with div<2; an=1110, num=0 in slots for idx0; an=1111 in slots for idx1-3 (leading zeros blanked); busy=0, ovf=0.
- Conversion timing: load bin=1234 at t. Expect busy=1 for t+1..t+15; digits {1,2,3,4} from t+16. Over a scan cycle, num sequence is 4,3,2,1 and an is 1110,1101,1011,0111 active from cycle 2 of each slot.
- Leading-zero blanking: load 7 -> only an[0] ever goes low, num=7. Load 1005 -> all four digits are enabled, with num 5,0,0,1.
- Saturation: load 12000 -> digits 9,9,9,9 and ovf=1. A following load of 42 -> ovf=0, digits 2,4, and digits 2,3 blanked.
- Load while busy: load 1111 at t, 2222 at t+3, 3333 at t+5. Display shows 1111 at t+16, then 3333 after a second conversion; 2222 is never displayed; busy stays high continuously between the two conversions.
- Reset mid-conversion: load 9876, assert rst_n=0 at t+7 for 1 cycle. Expect busy=0, digits all 0, an=1110 pattern only, and no 9876 ever committed.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Purpose: binary -> BCD (shift-add-3) converter feeding a time-multiplexed seven-segment scan.
// Latency: load at cycle t commits new digits visible from t+BIN_W+2; num lags idx by 1 cycle.
// Backpressure: none; loads while busy are queued (latest wins) and never abort a conversion.
module seg_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 100000,
  parameter int MAXVAL   = 9999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] bin,
  input  logic             load,
  output logic             busy,
  output logic [3:0]       num,
  output logic [NDIG-1:0]  an,
  output logic             ovf
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * NDIG;
  localparam logic [BIN_W-1:0] MAXV = BIN_W'(MAXVAL);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [BIN_W-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_nxt_q, ovf_nxt_d;
  logic                   ovf_q, ovf_d;
  logic                   pend_q, pend_d;
  logic [BIN_W-1:0]       pend_val_q, pend_val_d;
  logic                   pend_ovf_q, pend_ovf_d;
  logic [NDIG-1:0][3:0]   dig_q, dig_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [3:0]             num_q, num_d;

  logic                   over;
  logic [BIN_W-1:0]       sat_val;
  logic [BCD_W-1:0]       adj;
  logic [NDIG-1:0]        lead_blank;

  // Saturate the incoming value and pre-adjust every BCD nibble for the next shift.
  always_comb begin
    over    = (bin > MAXV);
    sat_val = over ? MAXV : bin;
    adj     = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: next state, shift datapath, pending-load queue and digit commit.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_nxt_d  = ovf_nxt_q;
    ovf_d      = ovf_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    pend_ovf_d = pend_ovf_q;
    dig_d      = dig_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          bin_d     = sat_val;
          bcd_d     = '0;
          cnt_d     = '0;
          ovf_nxt_d = over;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (load) begin
          pend_d     = 1'b1;
          pend_val_d = sat_val;
          pend_ovf_d = over;
        end
        bcd_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        for (int i = 0; i < NDIG; i++) begin
          dig_d[i] = bcd_q[4*i +: 4];
        end
        ovf_d = ovf_nxt_q;
        bcd_d = '0;
        cnt_d = '0;
        if (load) begin
          // A fresh load beats any queued value; the queue is dropped.
          bin_d     = sat_val;
          ovf_nxt_d = over;
          pend_d    = 1'b0;
          state_d   = S_SHIFT;
        end else if (pend_q) begin
          bin_d     = pend_val_q;
          ovf_nxt_d = pend_ovf_q;
          pend_d    = 1'b0;
          state_d   = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Refresh scan: slot divider, digit index and registered digit for the decoder.
  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end
    num_d = dig_q[idx_q];
  end

  // Anode drive: blank the first two cycles of each slot and any leading-zero digit.
  always_comb begin
    logic nz;
    nz = 1'b0;
    lead_blank = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      nz            = nz | (dig_q[i] != 4'd0);
      lead_blank[i] = ~nz;
    end
    lead_blank[0] = 1'b0;
    an = '1;
    if ((div_q >= DIV_W'(2)) && !lead_blank[idx_q]) begin
      an[idx_q] = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_nxt_q  <= 1'b0;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      pend_ovf_q <= 1'b0;
      dig_q      <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      num_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_nxt_q  <= ovf_nxt_d;
      ovf_q      <= ovf_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      pend_ovf_q <= pend_ovf_d;
      dig_q      <= dig_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      num_q      <= num_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign num  = num_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: decimal-arithmetic reference model checked every cycle,
// plus hand-computed expectations for timing, scan order and blanking.
module tb_seg_scan_ctrl;
  localparam int NDIG     = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;
  localparam int MAXVAL   = 9999;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [BIN_W-1:0] bin;
  logic             load;
  logic             busy;
  logic [3:0]       num;
  logic [NDIG-1:0]  an;
  logic             ovf;

  int n_total = 0;
  int n_bad   = 0;

  seg_scan_ctrl #(
    .NDIG(NDIG), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .MAXVAL(MAXVAL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bin(bin), .load(load),
    .busy(busy), .num(num), .an(an), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (decimal value level) ----------------
  bit m_on = 0;
  int m_left, m_cur, m_pend_val, m_disp, m_div, m_idx, m_num;
  bit m_cur_ovf, m_pend, m_pend_ovf, m_ovf;

  function automatic int pow10(input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r = r * 10;
    return r;
  endfunction

  function automatic int sat(input int x);
    return (x > MAXVAL) ? MAXVAL : x;
  endfunction

  function automatic logic [NDIG-1:0] exp_an();
    logic [NDIG-1:0] e = '1;
    if (m_div >= 2 && !(m_idx > 0 && m_disp < pow10(m_idx))) e[m_idx] = 1'b0;
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on = 1; m_left = 0; m_cur = 0; m_cur_ovf = 0; m_pend = 0; m_pend_val = 0;
      m_pend_ovf = 0; m_disp = 0; m_ovf = 0; m_div = 0; m_idx = 0; m_num = 0;
    end else if (m_on) begin
      m_num = (m_disp / pow10(m_idx)) % 10;
      if (m_div == SCAN_DIV - 1) begin
        m_div = 0;
        m_idx = (m_idx + 1) % NDIG;
      end else begin
        m_div++;
      end
      if (m_left == 0) begin
        if (load) begin
          m_cur = sat(int'(bin)); m_cur_ovf = (int'(bin) > MAXVAL); m_left = BIN_W + 1;
        end
      end else if (m_left == 1) begin
        m_disp = m_cur; m_ovf = m_cur_ovf;
        if (load) begin
          m_cur = sat(int'(bin)); m_cur_ovf = (int'(bin) > MAXVAL); m_left = BIN_W + 1; m_pend = 0;
        end else if (m_pend) begin
          m_cur = m_pend_val; m_cur_ovf = m_pend_ovf; m_left = BIN_W + 1; m_pend = 0;
        end else begin
          m_left = 0;
        end
      end else begin
        if (load) begin
          m_pend = 1; m_pend_val = sat(int'(bin)); m_pend_ovf = (int'(bin) > MAXVAL);
        end
        m_left--;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_on) begin
      check("busy", busy, (m_left > 0));
      check("ovf", ovf, m_ovf);
      check("num", num, m_num);
      check("an", an, exp_an());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    @(posedge clk);
    #1;
    bin  = BIN_W'(v);
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1; break; end
    end
    check("idle_timeout", ok, 1);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
      else break;
    end
  endtask

  int lowcnt [NDIG];

  // One full scan (NDIG slots) of anode activity, per digit.
  task automatic watch16();
    for (int d = 0; d < NDIG; d++) lowcnt[d] = 0;
    for (int c = 0; c < NDIG * SCAN_DIV; c++) begin
      @(negedge clk);
      for (int d = 0; d < NDIG; d++) if (an[d] === 1'b0) lowcnt[d]++;
    end
  endtask

  task automatic check_lows(input string name, input int l0, input int l1, input int l2, input int l3);
    watch16();
    check({name, "_an0"}, lowcnt[0], l0);
    check({name, "_an1"}, lowcnt[1], l1);
    check({name, "_an2"}, lowcnt[2], l2);
    check({name, "_an3"}, lowcnt[3], l3);
  endtask

  // Align to the first active cycle of digit 0, then sample each slot's first active cycle.
  task automatic check_scan(input string name, input int d0, input int d1, input int d2, input int d3);
    logic [3:0] ea [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int en [4];
    bit ok = 0;
    en[0] = d0; en[1] = d1; en[2] = d2; en[3] = d3;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an === 4'b1111) begin ok = 1; break; end
    end
    if (ok) begin
      ok = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (an === 4'b1110) begin ok = 1; break; end
      end
    end
    check({name, "_align"}, ok, 1);
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        check({name, "_scan_an"}, an, ea[k]);
        check({name, "_scan_num"}, num, en[k]);
        repeat (SCAN_DIV) @(negedge clk);
      end
    end
  endtask

  int nb;

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    bin   = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state: only digit 0 lit (showing 0), idle, no overflow.
    check_lows("reset", 2, 0, 0, 0);
    check("reset_busy", busy, 0);
    check("reset_ovf", ovf, 0);

    // 1234: 15 busy cycles, then scan 4,3,2,1 on anodes 0..3.
    do_load(1234);
    count_busy(nb);
    check("busy_len_1234", nb, 15);
    check_scan("v1234", 4, 3, 2, 1);

    // 7: only digit 0 ever enabled.
    do_load(7);
    wait_idle();
    check_lows("v7", 2, 0, 0, 0);

    // 1005: interior zeros are shown.
    do_load(1005);
    wait_idle();
    check_scan("v1005", 5, 0, 0, 1);

    // 12000 saturates to 9999.
    do_load(12000);
    wait_idle();
    check("sat_ovf", ovf, 1);
    check_scan("v12000", 9, 9, 9, 9);

    // 42 clears overflow and blanks the top two digits.
    do_load(42);
    wait_idle();
    check("ovf_clear", ovf, 0);
    check_lows("v42", 2, 2, 0, 0);

    // Loads while busy: 1111 at t, 2222 at t+3, 3333 at t+5.
    do_load(1111);
    tick();
    do_load(2222);
    do_load(3333);
    count_busy(nb);
    check("busy_len_pend", nb, 25);
    check_scan("v3333", 3, 3, 3, 3);

    // Reset in the middle of a conversion.
    do_load(9876);
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check_lows("midrst", 2, 0, 0, 0);
    repeat (30) @(negedge clk);
    check("midrst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
